// File: rtl/apb_pkg.sv
// Shared definitions for the APB register completer: access phase encoding,
// register word indices and the layout of the statistics word.
package apb_pkg;

  // Phase of the APB transfer as seen by the completer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_phase_e;

  // Word indices inside the register window.
  localparam int REG_ID    = 0;
  localparam int REG_STATS = 1;
  localparam int REG_CTRL  = 2;

  // Statistics word: write count in the low half, error count in the high half.
  localparam int STATS_WR_LSB  = 0;
  localparam int STATS_ERR_LSB = 16;
  localparam int STATS_CNT_W   = 16;

  // Assemble the statistics word from the two counters.
  function automatic logic [31:0] pack_stats(input logic [STATS_CNT_W-1:0] err_cnt,
                                             input logic [STATS_CNT_W-1:0] wr_cnt);
    logic [31:0] w_stats;
    w_stats = '0;
    w_stats[STATS_ERR_LSB +: STATS_CNT_W] = err_cnt;
    w_stats[STATS_WR_LSB  +: STATS_CNT_W] = wr_cnt;
    return w_stats;
  endfunction

endpackage

// File: rtl/apb_phase_fsm.sv
// APB phase tracker: follows IDLE/SETUP/ACCESS, remembers the setup-phase
// address and direction, and produces single-edge strobes for setup capture,
// clean commits and requester protocol errors.
module apb_phase_fsm
  import apb_pkg::*;
(
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] i_paddr,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic        i_pwrite,
  output logic        o_capture,  // this edge enters or stays in SETUP
  output logic        o_commit,   // this edge is a clean SETUP->ACCESS
  output logic        o_error     // this edge detects a protocol error
);

  apb_phase_e  r_state;
  apb_phase_e  w_next;
  logic [31:0] r_addr;
  logic        r_write;
  logic        w_mismatch;

  assign w_mismatch = (i_paddr != r_addr) || (i_pwrite != r_write);

  // Next-state decode and per-edge strobes.
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next    = r_state;
    o_capture = 1'b0;
    o_commit  = 1'b0;
    o_error   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_psel && !i_penable) begin
          w_next    = SETUP;
          o_capture = 1'b1;
        end else if (i_psel && i_penable) begin
          o_error = 1'b1;  // access strobe with no setup phase
        end
      end
      SETUP: begin
        if (i_psel && i_penable) begin
          w_next = ACCESS;
          // A changed address or direction still completes the access phase,
          // but the transfer itself is discarded.
          if (w_mismatch) o_error  = 1'b1;
          else            o_commit = 1'b1;
        end else if (i_psel) begin
          o_error   = 1'b1;  // repeated setup: restart with the new values
          o_capture = 1'b1;
        end else begin
          o_error = 1'b1;    // requester abandoned the transfer
          w_next  = IDLE;
        end
      end
      ACCESS: begin
        if (!i_psel) begin
          w_next = IDLE;
        end else if (!i_penable) begin
          w_next    = SETUP;  // back-to-back transfer
          o_capture = 1'b1;
        end else begin
          o_error = 1'b1;     // extended access is not supported
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Phase register plus the setup-phase address/direction snapshot.
  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // design samples pre-edge values regardless of block ordering.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next;
      if (o_capture) begin
        r_addr  <= i_paddr;
        r_write <= i_pwrite;
      end
    end
  end

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer exposing a small register window: a read-only ID word, a
// read-only statistics word and read/write registers, the first of which
// drives ctrl_o. Transfers always complete without wait states.
module apb_reg_completer
  import apb_pkg::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE  = 32'hA9B0_0001
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic [31:0] ctrl_o,
  output logic        proto_err_o
);

  localparam int                IDX_W     = $clog2(NUM_REGS);
  localparam logic [31:0]       WIN_MASK  = ~(32'(NUM_REGS * 4) - 32'd1);
  localparam logic [IDX_W-1:0]  IDX_ID    = IDX_W'(REG_ID);
  localparam logic [IDX_W-1:0]  IDX_STATS = IDX_W'(REG_STATS);
  localparam logic [IDX_W-1:0]  IDX_CTRL  = IDX_W'(REG_CTRL);

  // Address decode; the byte offset bits play no part in it.
  logic [IDX_W-1:0] w_idx;
  logic             w_hit;

  assign w_idx = paddr[IDX_W+1:2];
  assign w_hit = (paddr & WIN_MASK) == BASE_ADDR;

  // Phase tracking and transfer strobes.
  logic w_capture;
  logic w_commit;
  logic w_error;

  apb_phase_fsm u_phase_fsm (
    .pclk      (pclk),
    .presetn   (presetn),
    .i_paddr   (paddr),
    .i_psel    (psel),
    .i_penable (penable),
    .i_pwrite  (pwrite),
    .o_capture (w_capture),
    .o_commit  (w_commit),
    .o_error   (w_error)
  );

  // Write-side qualification of a clean commit.
  logic w_wr_commit;
  logic w_clear_cnt;
  logic w_reg_wr;

  assign w_wr_commit = w_commit && pwrite && w_hit;
  assign w_clear_cnt = w_wr_commit && (w_idx == IDX_STATS);
  assign w_reg_wr    = w_wr_commit && (w_idx >= IDX_CTRL);

  // Storage. Words 0 and 1 are never written; their slots only keep the
  // array indexable by the raw word index.
  logic [31:0]            r_regs [NUM_REGS];
  logic [STATS_CNT_W-1:0] r_wr_cnt;
  logic [STATS_CNT_W-1:0] r_err_cnt;
  logic [31:0]            r_prdata;
  logic                   r_proto_err;
  logic [31:0]            w_rd_value;

  // Read data for the word addressed this cycle; misses read as zero.
  always_comb begin
    w_rd_value = '0;
    if (w_hit) begin
      case (w_idx)
        IDX_ID:    w_rd_value = ID_VALUE;
        IDX_STATS: w_rd_value = pack_stats(r_err_cnt, r_wr_cnt);
        default:   w_rd_value = r_regs[w_idx];
      endcase
    end
  end

  // Read/write register file.
  // NOTE: the register array is reset explicitly because word 2 is visible on
  // ctrl_o straight out of reset and reads must return zero, not garbage.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_reg_wr) begin
      r_regs[w_idx] <= pwdata;
    end
  end

  // Write counter (wrapping) and error counter (saturating); a statistics
  // write clears both and can never coincide with an error.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_wr_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (w_clear_cnt) begin
      r_wr_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_reg_wr) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_error && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  // Read data is loaded at read setup and held until the next read setup.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_prdata <= '0;
    end else if (w_capture && !pwrite) begin
      r_prdata <= w_rd_value;
    end
  end

  // One-cycle protocol error pulse following the offending edge.
  always_ff @(posedge pclk) begin
    if (!presetn) r_proto_err <= 1'b0;
    else          r_proto_err <= w_error;
  end

  assign prdata      = r_prdata;
  assign ctrl_o      = r_regs[REG_CTRL];
  assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Self-checking bench for apb_reg_completer (NUM_REGS=8, BASE_ADDR=0).
module tb_apb_reg_completer;

  localparam logic [31:0] ID_VAL = 32'hA9B0_0001;

  logic        pclk;
  logic        presetn;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic [31:0] ctrl_o;
  logic        proto_err_o;

  apb_reg_completer #(
    .NUM_REGS  (8),
    .BASE_ADDR (32'h0000_0000),
    .ID_VALUE  (ID_VAL)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .ctrl_o      (ctrl_o),
    .proto_err_o (proto_err_o)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;   // expected prdata for reads
    bit          b2b;   // next transfer follows with no idle cycle
  } vec_t;

  int          n_checks;
  int          n_errors;
  int          pulse_cnt;
  logic [31:0] sb_q[$];
  logic [31:0] last_rd;
  logic [31:0] m_ctrl;
  vec_t        vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive inputs, wait for the edge, sample 1 ns later.
  task automatic drive(input logic s, input logic e, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
    @(posedge pclk);
    #1;
    if (proto_err_o) pulse_cnt++;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Complete a clean transfer and compare prdata via the scoreboard.
  task automatic run_vec(input string tag, input vec_t v);
    logic [31:0] exp_rd;
    exp_rd = v.wr ? last_rd : v.exp;
    sb_q.push_back(exp_rd);
    drive(1'b1, 1'b0, v.wr, v.addr, v.data);
    drive(1'b1, 1'b1, v.wr, v.addr, v.data);
    check({tag, " prdata"}, prdata, sb_q.pop_front());
    last_rd = exp_rd;
    if (v.wr && v.addr[31:5] == '0 && v.addr[4:2] == 3'd2) m_ctrl = v.data;
    check({tag, " ctrl_o"}, ctrl_o, m_ctrl);
    check({tag, " proto_err"}, 32'(proto_err_o), 32'd0);
    if (!v.b2b) idle();
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] e, input bit b);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp = e; v.b2b = b;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_errors = 0; pulse_cnt = 0;
    last_rd = 32'h0; m_ctrl = 32'h0;
    presetn = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;

    vecs[0]  = mk(1'b0, 32'h00, 32'h0,          ID_VAL,       1'b0);
    vecs[1]  = mk(1'b0, 32'h04, 32'h0,          32'h0,        1'b0);
    vecs[2]  = mk(1'b1, 32'h08, 32'h1234_5678,  32'h0,        1'b0);
    vecs[3]  = mk(1'b0, 32'h08, 32'h0,          32'h1234_5678, 1'b0);
    vecs[4]  = mk(1'b0, 32'h04, 32'h0,          32'h0000_0001, 1'b0);
    vecs[5]  = mk(1'b1, 32'h0C, 32'hCAFE_0001,  32'h0,        1'b1);
    vecs[6]  = mk(1'b1, 32'h10, 32'hBEEF_0002,  32'h0,        1'b1);
    vecs[7]  = mk(1'b0, 32'h0C, 32'h0,          32'hCAFE_0001, 1'b1);
    vecs[8]  = mk(1'b0, 32'h10, 32'h0,          32'hBEEF_0002, 1'b0);
    vecs[9]  = mk(1'b0, 32'h04, 32'h0,          32'h0000_0003, 1'b0);
    vecs[10] = mk(1'b1, 32'h00, 32'hFFFF_FFFF,  32'h0,        1'b0);
    vecs[11] = mk(1'b1, 32'h40, 32'h1111_1111,  32'h0,        1'b0);
    vecs[12] = mk(1'b1, 32'h1C, 32'h0000_0077,  32'h0,        1'b0);
    vecs[13] = mk(1'b0, 32'h00, 32'h0,          ID_VAL,       1'b0);
    vecs[14] = mk(1'b0, 32'h40, 32'h0,          32'h0,        1'b0);
    vecs[15] = mk(1'b0, 32'h1C, 32'h0,          32'h0000_0077, 1'b0);
    vecs[16] = mk(1'b0, 32'h0B, 32'h0,          32'h1234_5678, 1'b0);
    vecs[17] = mk(1'b0, 32'h04, 32'h0,          32'h0000_0004, 1'b0);

    // Reset state.
    idle(); idle();
    presetn = 1'b1;
    idle();
    check("reset prdata", prdata, 32'h0);
    check("reset ctrl_o", ctrl_o, 32'h0);
    check("reset proto_err", 32'(proto_err_o), 32'd0);

    // Clean transfers, including back-to-back, miss and boundary words.
    for (int i = 0; i < 18; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Protocol errors: each must pulse proto_err_o for exactly one cycle.
    pulse_cnt = 0;
    drive(1'b1, 1'b1, 1'b0, 32'h00, 32'h0);             // penable without setup
    check("err1 pulse", 32'(proto_err_o), 32'd1);
    idle();
    check("err1 pulse end", 32'(proto_err_o), 32'd0);

    drive(1'b1, 1'b0, 1'b1, 32'h08, 32'hDEAD_BEEF);     // setup, then psel drops
    drive(1'b0, 1'b0, 1'b1, 32'h08, 32'hDEAD_BEEF);
    check("err2 pulse", 32'(proto_err_o), 32'd1);
    idle();

    drive(1'b1, 1'b0, 1'b0, 32'h00, 32'h0);             // read held two access cycles
    drive(1'b1, 1'b1, 1'b0, 32'h00, 32'h0);
    check("err3 first access", 32'(proto_err_o), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h00, 32'h0);
    check("err3 pulse", 32'(proto_err_o), 32'd1);
    last_rd = ID_VAL;
    check("err3 prdata", prdata, ID_VAL);
    idle();

    drive(1'b1, 1'b0, 1'b1, 32'h08, 32'hDEAD_BEEF);     // address changes at access
    drive(1'b1, 1'b1, 1'b1, 32'h0C, 32'hDEAD_BEEF);
    check("err4 pulse", 32'(proto_err_o), 32'd1);
    idle();
    check("err4 ctrl_o", ctrl_o, 32'h1234_5678);
    check("error pulse count", 32'(pulse_cnt), 32'd4);

    run_vec("post-err reg2", mk(1'b0, 32'h08, 32'h0, 32'h1234_5678, 1'b0));
    run_vec("post-err reg3", mk(1'b0, 32'h0C, 32'h0, 32'hCAFE_0001, 1'b0));
    run_vec("post-err stats", mk(1'b0, 32'h04, 32'h0, 32'h0004_0004, 1'b0));

    // Counter clear.
    run_vec("clear write", mk(1'b1, 32'h04, 32'h0000_5A5A, 32'h0, 1'b0));
    run_vec("clear stats", mk(1'b0, 32'h04, 32'h0, 32'h0, 1'b0));

    // Reset between setup and access of a write abandons the transfer.
    run_vec("pre-rst reg2", mk(1'b0, 32'h08, 32'h0, 32'h1234_5678, 1'b0));
    drive(1'b1, 1'b0, 1'b1, 32'h08, 32'hA5A5_A5A5);
    presetn = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h08, 32'hA5A5_A5A5);
    idle();
    presetn = 1'b1;
    idle();
    m_ctrl = 32'h0; last_rd = 32'h0;
    check("mid-rst prdata", prdata, 32'h0);
    check("mid-rst ctrl_o", ctrl_o, 32'h0);
    check("mid-rst proto_err", 32'(proto_err_o), 32'd0);
    run_vec("mid-rst reg2", mk(1'b0, 32'h08, 32'h0, 32'h0, 1'b0));
    run_vec("mid-rst reg3", mk(1'b0, 32'h0C, 32'h0, 32'h0, 1'b0));
    run_vec("mid-rst stats", mk(1'b0, 32'h04, 32'h0, 32'h0, 1'b0));
    run_vec("mid-rst id", mk(1'b0, 32'h00, 32'h0, ID_VAL, 1'b0));

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
